// File: rtl/div11_rr_sched_if.sv
// Request/response bundle for the shared mod-11 unit.
// Optional rsp_q member when DIV11_SCHED_QUOT_EN is defined.
interface div11_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int XW      = 64,
    parameter int RW      = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*XW-1:0] req_x;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [RW-1:0]         rsp_r;
    logic                  flush;
    logic                  flush_done;
    logic [NUM_REQ-1:0]    busy;
`ifdef DIV11_SCHED_QUOT_EN
    logic [XW-3:1]         rsp_q;

    modport master (
        output req_valid, req_x, flush,
        input  req_ready, rsp_valid, rsp_r, flush_done, busy, rsp_q
    );
    modport slave (
        input  req_valid, req_x, flush,
        output req_ready, rsp_valid, rsp_r, flush_done, busy, rsp_q
    );
`else
    modport master (
        output req_valid, req_x, flush,
        input  req_ready, rsp_valid, rsp_r, flush_done, busy
    );
    modport slave (
        input  req_valid, req_x, flush,
        output req_ready, rsp_valid, rsp_r, flush_done, busy
    );
`endif
endinterface

// File: rtl/div11_rr_sched.sv
// Round-robin shared X mod 11 unit, 2-stage tagged pipeline, flush FSM.
// Define DIV11_SCHED_QUOT_EN to also return floor(X/11) on rsp_q.
module div11_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int XW      = 64,
    parameter int RW      = 4
) (
    input logic             clk,
    input logic             rst_n,
    div11_rr_sched_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] r_busy;
    logic [XW-1:0]      r_x0;
    logic [PW-1:0]      r_tag0;
    logic               r_v0;
    logic [RW-1:0]      r_r1;
    logic [PW-1:0]      r_tag1;
    logic               r_v1;

    logic               w_run_ok;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [PW-1:0]      w_gidx;
    logic               w_found;
    logic [PW:0]        w_sum;
    logic [PW-1:0]      w_idx;
    logic [XW-1:0]      w_xsel;
    logic [NUM_REQ-1:0] w_rsp;
    logic [RW-1:0]      w_rem;

    assign w_run_ok = (r_state == RUN) & ~bus.flush & rst_n;
    assign w_elig   = bus.req_valid & ~r_busy & {NUM_REQ{w_run_ok}};
    assign w_rem    = RW'(r_x0 % XW'(11));

    // Search from r_ptr, wrapping, for the first eligible requester
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NUM_REQ))
                w_sum = w_sum - (PW+1)'(NUM_REQ);
            w_idx = w_sum[PW-1:0];
            if (!w_found && w_elig[w_idx]) begin
                w_found        = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gidx         = w_idx;
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        w_xsel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_grant[i])
                w_xsel = bus.req_x[i*XW +: XW];
    end

    // One-hot response pulse to the owner of the S1 result
    always_comb begin
        w_rsp = '0;
        if (r_v1)
            w_rsp[r_tag1] = 1'b1;
    end

    // Flush FSM next state: drain until pipeline and busy flags are empty
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:     if (bus.flush) w_state_nxt = DRAIN;
            DRAIN:   if (!r_v0 && !r_v1 && !(|r_busy))
                         w_state_nxt = bus.flush ? HALT : RUN;
            HALT:    if (!bus.flush) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // State, round-robin pointer and outstanding flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_ptr   <= '0;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_found)
                r_ptr <= (w_gidx == PW'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
            r_busy <= (r_busy | w_grant) & ~w_rsp;
        end
    end

    // S0 captures the granted operand and its tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0   <= 1'b0;
            r_x0   <= '0;
            r_tag0 <= '0;
        end else begin
            r_v0 <= w_found;
            if (w_found) begin
                r_x0   <= w_xsel;
                r_tag0 <= w_gidx;
            end
        end
    end

    // S1 captures the remainder; it holds when no op advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_r1   <= '0;
            r_tag1 <= '0;
        end else begin
            r_v1 <= r_v0;
            if (r_v0) begin
                r_r1   <= w_rem;
                r_tag1 <= r_tag0;
            end
        end
    end

`ifdef DIV11_SCHED_QUOT_EN
    logic [XW-3:1] r_q1;
    logic [XW-3:1] w_quo;

    assign w_quo = (XW-3)'(r_x0 / XW'(11));

    // Quotient travels alongside the remainder in S1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q1 <= '0;
        else if (r_v0)
            r_q1 <= w_quo;
    end

    assign bus.rsp_q = r_q1;
`endif

    assign bus.req_ready  = w_grant;
    assign bus.rsp_valid  = w_rsp;
    assign bus.rsp_r      = r_r1;
    assign bus.flush_done = (r_state == HALT);
    assign bus.busy       = r_busy;

endmodule
